// File: rtl/periph_bus_arbiter.sv
// Two-master round-robin arbiter and sequencer for the 16-bit peripheral register bus.
// Holds id/strobes for WAIT_CYCLES+1 cycles, captures read data, then pulses the granted master's ack.
module periph_bus_arbiter #(
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [15:0] m0_id,
  input  logic [15:0] m0_wdata,
  output logic        m0_ack,
  output logic [15:0] m0_rdata,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [15:0] m1_id,
  input  logic [15:0] m1_wdata,
  output logic        m1_ack,
  output logic [15:0] m1_rdata,
  output logic [15:0] bus_id,
  output logic        bus_read,
  output logic        bus_write,
  output logic [15:0] bus_wdata,
  input  logic [15:0] bus_rdata,
  output logic        busy,
  output logic        owner
);

  typedef enum logic [1:0] {IDLE, ACCESS, ACK} state_t;

  localparam logic [7:0] WAIT_INIT = 8'(WAIT_CYCLES);

  state_t      state, state_nx;
  logic [7:0]  count, count_nx;
  logic        m0_ack_nx, m1_ack_nx, owner_nx, busy_nx;
  logic        bus_read_nx, bus_write_nx;
  logic [15:0] m0_rdata_nx, m1_rdata_nx, bus_id_nx, bus_wdata_nx;

  logic        grant;
  logic        sel_we;
  logic [15:0] sel_id, sel_wdata;

  // On contention the master that did not win last time gets the bus.
  assign grant     = (m0_req & m1_req) ? ~owner : m1_req;
  assign sel_we    = grant ? m1_we    : m0_we;
  assign sel_id    = grant ? m1_id    : m0_id;
  assign sel_wdata = grant ? m1_wdata : m0_wdata;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      count     <= 8'd0;
      m0_ack    <= 1'b0;
      m1_ack    <= 1'b0;
      m0_rdata  <= 16'd0;
      m1_rdata  <= 16'd0;
      bus_id    <= 16'd0;
      bus_read  <= 1'b0;
      bus_write <= 1'b0;
      bus_wdata <= 16'd0;
      busy      <= 1'b0;
      owner     <= 1'b1;
    end else begin
      state     <= state_nx;
      count     <= count_nx;
      m0_ack    <= m0_ack_nx;
      m1_ack    <= m1_ack_nx;
      m0_rdata  <= m0_rdata_nx;
      m1_rdata  <= m1_rdata_nx;
      bus_id    <= bus_id_nx;
      bus_read  <= bus_read_nx;
      bus_write <= bus_write_nx;
      bus_wdata <= bus_wdata_nx;
      busy      <= busy_nx;
      owner     <= owner_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    count_nx     = count;
    m0_ack_nx    = 1'b0;
    m1_ack_nx    = 1'b0;
    m0_rdata_nx  = m0_rdata;
    m1_rdata_nx  = m1_rdata;
    bus_id_nx    = bus_id;
    bus_read_nx  = bus_read;
    bus_write_nx = bus_write;
    bus_wdata_nx = bus_wdata;
    busy_nx      = busy;
    owner_nx     = owner;

    case (state)
      IDLE: begin
        bus_id_nx    = 16'd0;
        bus_read_nx  = 1'b0;
        bus_write_nx = 1'b0;
        bus_wdata_nx = 16'd0;
        busy_nx      = 1'b0;
        if (m0_req | m1_req) begin
          owner_nx     = grant;
          bus_id_nx    = sel_id;
          bus_read_nx  = ~sel_we;
          bus_write_nx = sel_we;
          bus_wdata_nx = sel_we ? sel_wdata : 16'd0;
          busy_nx      = 1'b1;
          count_nx     = WAIT_INIT;
          state_nx     = ACCESS;
        end
      end

      ACCESS: begin
        if (count != 8'd0) begin
          count_nx = count - 8'd1;
        end else begin
          // owner names the granted master for the whole transaction.
          if (bus_read) begin
            if (owner) m1_rdata_nx = bus_rdata;
            else       m0_rdata_nx = bus_rdata;
          end
          m0_ack_nx    = ~owner;
          m1_ack_nx    = owner;
          bus_id_nx    = 16'd0;
          bus_read_nx  = 1'b0;
          bus_write_nx = 1'b0;
          bus_wdata_nx = 16'd0;
          state_nx     = ACK;
        end
      end

      ACK: begin
        busy_nx  = 1'b0;
        state_nx = IDLE;
      end

      default: begin
        state_nx = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_periph_bus_arbiter.sv
// Scoreboard bench for periph_bus_arbiter: two lanes (WAIT_CYCLES=1 and 0), each with
// a transaction-level reference model feeding an expected-ack queue and a bus monitor.
module tb_periph_bus_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n  [2];
  logic        m0_req   [2];
  logic        m0_we    [2];
  logic [15:0] m0_id    [2];
  logic [15:0] m0_wdata [2];
  logic        m0_ack   [2];
  logic [15:0] m0_rdata [2];
  logic        m1_req   [2];
  logic        m1_we    [2];
  logic [15:0] m1_id    [2];
  logic [15:0] m1_wdata [2];
  logic        m1_ack   [2];
  logic [15:0] m1_rdata [2];
  logic [15:0] bus_id   [2];
  logic        bus_read [2];
  logic        bus_write[2];
  logic [15:0] bus_wdata[2];
  logic [15:0] bus_rdata[2];
  logic        busy     [2];
  logic        owner    [2];

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        master;
    int          ack_cycle;
    logic [15:0] rdata;
  } txn_t;

  // Stand-in for the peripheral read mux, with two fixed ids used by directed tests.
  function automatic logic [15:0] periph_data(input logic [15:0] id);
    if (id == 16'h0001) return 16'hA5A5;
    if (id == 16'h0BEE) return 16'hBEEF;
    return (id * 16'h9E37) ^ 16'h5A5A;
  endfunction

  task automatic checkOutput(input string name, input logic [35:0] actual, input logic [35:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : lane
    localparam int W = (g == 0) ? 1 : 0;

    periph_bus_arbiter #(.WAIT_CYCLES(W)) dut (
      .clk      (clk),
      .reset_n  (reset_n[g]),
      .m0_req   (m0_req[g]),
      .m0_we    (m0_we[g]),
      .m0_id    (m0_id[g]),
      .m0_wdata (m0_wdata[g]),
      .m0_ack   (m0_ack[g]),
      .m0_rdata (m0_rdata[g]),
      .m1_req   (m1_req[g]),
      .m1_we    (m1_we[g]),
      .m1_id    (m1_id[g]),
      .m1_wdata (m1_wdata[g]),
      .m1_ack   (m1_ack[g]),
      .m1_rdata (m1_rdata[g]),
      .bus_id   (bus_id[g]),
      .bus_read (bus_read[g]),
      .bus_write(bus_write[g]),
      .bus_wdata(bus_wdata[g]),
      .bus_rdata(bus_rdata[g]),
      .busy     (busy[g]),
      .owner    (owner[g])
    );

    assign bus_rdata[g] = periph_data(bus_id[g]);

    txn_t        expq[$];
    int          cyc = 0;
    int          free_at = 0;
    logic        mdl_owner = 1'b1;
    logic        cur_valid = 1'b0;
    int          cur_start = 0;
    logic        cur_master = 1'b0;
    logic        cur_we = 1'b0;
    logic [15:0] cur_id = 16'd0;
    logic [15:0] cur_wdata = 16'd0;
    logic [15:0] vis_rdata [2] = '{16'd0, 16'd0};

    // Reference model: a transaction occupies W+3 cycles from its grant edge, strobes for
    // the first W+1, read data lands and ack rises at edge W+1 after the grant.
    always @(posedge clk) begin : model
      logic m;
      cyc++;
      if (!reset_n[g]) begin
        expq.delete();
        mdl_owner    = 1'b1;
        cur_valid    = 1'b0;
        vis_rdata[0] = 16'd0;
        vis_rdata[1] = 16'd0;
        free_at      = cyc + 1;
      end else begin
        if (cur_valid && !cur_we && cyc == cur_start + W + 1)
          vis_rdata[cur_master] = periph_data(cur_id);
        if (cur_valid && cyc >= cur_start + W + 2)
          cur_valid = 1'b0;
        if (cyc >= free_at && (m0_req[g] || m1_req[g])) begin
          m          = (m0_req[g] && m1_req[g]) ? ~mdl_owner : m1_req[g];
          mdl_owner  = m;
          cur_valid  = 1'b1;
          cur_start  = cyc;
          cur_master = m;
          cur_we     = m ? m1_we[g]    : m0_we[g];
          cur_id     = m ? m1_id[g]    : m0_id[g];
          cur_wdata  = m ? m1_wdata[g] : m0_wdata[g];
          free_at    = cyc + W + 3;
          expq.push_back('{master: m, ack_cycle: cyc + W + 1,
                           rdata: cur_we ? vis_rdata[m] : periph_data(cur_id)});
        end
      end
    end

    // Monitor: bus and rdata every cycle; on any ack, pop and compare the expected completion.
    always @(negedge clk) begin : monitor
      logic act, bsy;
      txn_t t;
      act = cur_valid && cyc <= cur_start + W;
      bsy = cur_valid && cyc <= cur_start + W + 1;
      checkOutput($sformatf("lane%0d bus{busy,owner,rd,wr,id,wdata}", g),
                  {busy[g], owner[g], bus_read[g], bus_write[g], bus_id[g], bus_wdata[g]},
                  {bsy, mdl_owner, act & ~cur_we, act & cur_we,
                   act ? cur_id : 16'd0, (act && cur_we) ? cur_wdata : 16'd0});
      checkOutput($sformatf("lane%0d rdata{m0,m1}", g),
                  {4'd0, m0_rdata[g], m1_rdata[g]}, {4'd0, vis_rdata[0], vis_rdata[1]});
      if (m0_ack[g] || m1_ack[g]) begin
        checkOutput($sformatf("lane%0d acks exclusive", g), 36'(m0_ack[g] & m1_ack[g]), 36'd0);
        if (expq.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL lane%0d unexpected ack: m0_ack=%0b m1_ack=%0b, expected none at %0t",
                   g, m0_ack[g], m1_ack[g], $time);
        end else begin
          t = expq.pop_front();
          checkOutput($sformatf("lane%0d ack master", g), 36'(m1_ack[g]), 36'(t.master));
          checkOutput($sformatf("lane%0d ack cycle", g), 36'(cyc), 36'(t.ack_cycle));
          checkOutput($sformatf("lane%0d ack rdata", g),
                      36'(t.master ? m1_rdata[g] : m0_rdata[g]), 36'(t.rdata));
        end
      end else if (expq.size() != 0 && expq[0].ack_cycle <= cyc) begin
        checks++;
        errors++;
        $display("[TB] FAIL lane%0d missing ack: no ack observed, expected master %0b at cycle %0d",
                 g, expq[0].master, expq[0].ack_cycle);
        void'(expq.pop_front());
      end
    end
  end

  task automatic applyStimulus(input int l, input logic m, input logic req, input logic we,
                               input logic [15:0] id, input logic [15:0] wdata);
    if (m) begin
      m1_req[l] = req; m1_we[l] = we; m1_id[l] = id; m1_wdata[l] = wdata;
    end else begin
      m0_req[l] = req; m0_we[l] = we; m0_id[l] = id; m0_wdata[l] = wdata;
    end
  endtask

  task automatic waitAck(input int l, input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(m0_ack[l] || m1_ack[l]) && n < budget);
    checks++;
    if (!(m0_ack[l] || m1_ack[l])) begin
      errors++;
      $display("[TB] FAIL lane%0d ack timeout: none after %0d cycles, expected within %0d", l, n, budget);
    end
  endtask

  task automatic pulseReset(input int l);
    @(negedge clk);
    reset_n[l] = 1'b0;
    @(negedge clk);
    reset_n[l] = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      reset_n[i] = 1'b0;
      applyStimulus(i, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0);
      applyStimulus(i, 1'b1, 1'b0, 1'b0, 16'd0, 16'd0);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n[0] = 1'b1;
    reset_n[1] = 1'b1;
    repeat (5) @(negedge clk);

    // Lane 0 (one wait cycle): single m0 read of id 1.
    applyStimulus(0, 1'b0, 1'b1, 1'b0, 16'h0001, 16'h0);
    waitAck(0, 10);
    applyStimulus(0, 1'b0, 1'b0, 1'b0, 16'h0001, 16'h0);
    repeat (3) @(negedge clk);

    // Both masters hold read requests straight after reset: strict alternation.
    pulseReset(0);
    applyStimulus(0, 1'b0, 1'b1, 1'b0, 16'h0002, 16'h0);
    applyStimulus(0, 1'b1, 1'b1, 1'b0, 16'h0003, 16'h0);
    repeat (4) waitAck(0, 10);
    applyStimulus(0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    applyStimulus(0, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
    repeat (3) @(negedge clk);

    // m1 loads 0xBEEF by read, then writes; its rdata must not change.
    applyStimulus(0, 1'b1, 1'b1, 1'b0, 16'h0BEE, 16'h0);
    waitAck(0, 10);
    applyStimulus(0, 1'b1, 1'b1, 1'b1, 16'h0004, 16'h1234);
    @(negedge clk);
    waitAck(0, 10);
    applyStimulus(0, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
    repeat (3) @(negedge clk);

    // Reset in the first ACCESS cycle of an m0 read aborts it; a fresh read then completes.
    applyStimulus(0, 1'b0, 1'b1, 1'b0, 16'h0007, 16'h0);
    @(negedge clk);
    applyStimulus(0, 1'b0, 1'b0, 1'b0, 16'h0007, 16'h0);
    reset_n[0] = 1'b0;
    @(negedge clk);
    reset_n[0] = 1'b1;
    repeat (2) @(negedge clk);
    applyStimulus(0, 1'b0, 1'b1, 1'b0, 16'h0001, 16'h0);
    waitAck(0, 10);
    applyStimulus(0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);

    // Lane 1 (zero wait): m1 read of id 5, then m0 write whose id changes mid-transaction.
    applyStimulus(1, 1'b1, 1'b1, 1'b0, 16'h0005, 16'h0);
    waitAck(1, 10);
    applyStimulus(1, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
    repeat (2) @(negedge clk);
    applyStimulus(1, 1'b0, 1'b1, 1'b1, 16'h0010, 16'h55AA);
    @(negedge clk);
    applyStimulus(1, 1'b0, 1'b1, 1'b1, 16'h0020, 16'h0F0F);
    waitAck(1, 10);
    applyStimulus(1, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    repeat (3) @(negedge clk);

    // Randomized traffic on both lanes, including rare resets and mid-transaction field changes.
    repeat (3000) begin
      @(negedge clk);
      for (int l = 0; l < 2; l++) begin
        reset_n[l] = ($urandom_range(0, 299) != 0);
        for (int m = 0; m < 2; m++) begin
          if ($urandom_range(0, 3) == 0)
            applyStimulus(l, 1'(m), 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                          16'($urandom_range(0, 15)), 16'($urandom()));
        end
      end
    end
    for (int l = 0; l < 2; l++) begin
      reset_n[l] = 1'b1;
      applyStimulus(l, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
      applyStimulus(l, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
    end
    repeat (10) @(negedge clk);
    checkOutput("lane0 pending acks", 36'(lane[0].expq.size()), 36'd0);
    checkOutput("lane1 pending acks", 36'(lane[1].expq.size()), 36'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
